mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single shared memory bus. Requester 0 is the CPU core; requester 1 is the boot loader or a DMA engine. The block owns the memory-side address, write-data and write-enable signals. It grants the bus per access or per locked burst using round-robin priority, and caps burst length so neither requester can starve the other. The block sits between the requesters and the synchronous memory, replacing direct tri-state sharing of the data bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/arb_rr_pick.sv | 14 +
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths and FSM encodings for the memory bus arbiter and
// any future bus masters that sequence the same memory.
package mem_bus_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_ACCESS = 2'd1;
    localparam arb_state_t ST_RESP   = 2'd2;
    localparam arb_state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the requester
// that did not own the bus last wins.
module arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic pick
);

    assign valid = req0 | req1;
    assign pick  = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter and sequencer for the shared synchronous memory
// bus; grants per access or per capped locked burst, round-robin on ties.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W    = WORD_SIZE,
    parameter int ADDR_W    = ADDR_SIZE,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int            BW   = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BCAP = BW'(MAX_BURST - 1);

    arb_state_t    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q,  last_d;
    logic [BW-1:0] bcnt_q,  bcnt_d;

    logic              pick_valid;
    logic              pick;
    logic              own_req;
    logic              own_lock;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              in_access;
    logic              in_resp;

    arb_rr_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .valid (pick_valid),
        .pick  (pick)
    );

    assign own_req   = owner_q ? req1   : req0;
    assign own_lock  = owner_q ? lock1  : lock0;
    assign own_we    = owner_q ? we1    : we0;
    assign own_addr  = owner_q ? addr1  : addr0;
    assign own_wdata = owner_q ? wdata1 : wdata0;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick;
                    bcnt_d  = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (own_lock && (bcnt_q < BCAP)) begin
                    state_d = ST_HOLD;
                end else begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // The peer is ignored here; only the owner's req matters.
                if (own_req) begin
                    bcnt_d  = bcnt_q + BW'(1);
                    state_d = ST_ACCESS;
                end else begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);

    assign gnt0 = busy & ~owner_q;
    assign gnt1 = busy &  owner_q;
    assign ack0 = in_resp & ~owner_q;
    assign ack1 = in_resp &  owner_q;

    assign rdata     = in_resp   ? mem_rdata : '0;
    assign mem_addr  = in_access ? own_addr  : '0;
    assign mem_wdata = in_access ? own_wdata : '0;
    assign mem_wr_en = in_access & own_we;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed timing scenarios plus two random
// requesters, with per-requester expected-ack queues and a memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, ack0, ack1, mem_wr_en, busy;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    logic [DW-1:0] mem [256];
    logic [DW-1:0] refmem [256];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        bit            rd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    mem_bus_arbiter #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .lock0     (lock0),
        .lock1     (lock1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data appears one cycle after the address.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        while (cyc < n) step();
    endtask

    task automatic exp_rd(input int k, input logic [AW-1:0] a, input int c);
        exp_t e;
        e.rd = 1'b1;
        e.data = refmem[a];
        e.cyc = c;
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic exp_wr(input int k, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int c);
        exp_t e;
        refmem[a] = d;
        e.rd = 1'b0;
        e.data = '0;
        e.cyc = c;
        if (k == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic drive(input int k, input bit r, input bit l, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (k == 0) begin
            req0 = r; lock0 = l; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; lock1 = l; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic mon_ack(input int k);
        exp_t e;
        int   n;
        n = (k == 0) ? sb0.size() : sb1.size();
        chk(k == 0 ? "ack0_expected" : "ack1_expected", 32'(n > 0), 1);
        if (n > 0) begin
            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            if (e.rd)
                chk(k == 0 ? "ack0_rdata" : "ack1_rdata",
                    32'(rdata), 32'(e.data));
            if (e.cyc >= 0)
                chk(k == 0 ? "ack0_cycle" : "ack1_cycle", cyc, e.cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("gnt_onehot", 32'(gnt0 & gnt1), 0);
                chk("wr_en_owned", 32'(mem_wr_en & ~(gnt0 | gnt1)), 0);
                if (ack0) mon_ack(0);
                if (ack1) mon_ack(1);
            end
        end
    end

    task automatic requester(input int k);
        int            gap;
        bit            got;
        bit            w;
        bit            l;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
                repeat (gap) step();
            end
            a = AW'((k == 0) ? $urandom_range(0, 127)
                             : $urandom_range(128, 255));
            w = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 2) == 0);
            d = DW'($urandom);
            drive(k, 1'b1, l, w, a, d);
            if (w) exp_wr(k, a, d, -1);
            else exp_rd(k, a, -1);
            got = 1'b0;
            for (int t = 0; t < 120 && !got; t++) begin
                @(negedge clk);
                got = (k == 0) ? ack0 : ack1;
            end
            chk(k == 0 ? "rnd0_ack_seen" : "rnd1_ack_seen", 32'(got), 1);
            if (!got) break;
            step();
        end
        drive(k, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            c0;
        logic [AW-1:0] a;

        // Preload memory and reference while reset is held.
        for (int i = 0; i < 256; i++) begin
            step();
            bd_we = 1'b1;
            bd_addr = AW'(i);
            bd_data = (i == 16) ? 16'hBEEF : DW'($urandom);
            refmem[i] = bd_data;
        end
        step();
        bd_we = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 32'({gnt0, gnt1}), 0);
        chk("rst_ack", 32'({ack0, ack1}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_mem_bus", 32'({mem_addr, mem_wdata, mem_wr_en}), 0);

        // Tie after reset: req0 first, then req1; second tie to req0.
        step();
        rst = 1'b0;
        step();
        c0 = cyc;
        drive(0, 1'b1, 1'b0, 1'b0, 8'h05, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h85, '0);
        exp_rd(0, 8'h05, c0 + 2);
        exp_rd(1, 8'h85, c0 + 5);
        go(c0 + 1);
        @(negedge clk);
        chk("t2_gnt", 32'({gnt0, gnt1}), 32'b10);
        chk("t2_addr", 32'(mem_addr), 32'h05);
        go(c0 + 3);
        req0 = 1'b0;
        @(negedge clk);
        chk("t2_idle", 32'(busy), 0);
        go(c0 + 4);
        @(negedge clk);
        chk("t2_gnt1", 32'({gnt0, gnt1}), 32'b01);
        go(c0 + 6);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h06, '0);
        addr1 = 8'h86;
        exp_rd(0, 8'h06, c0 + 8);
        exp_rd(1, 8'h86, c0 + 11);
        go(c0 + 7);
        @(negedge clk);
        chk("t2_tie2_gnt0", 32'({gnt0, gnt1}), 32'b10);
        go(c0 + 9);
        req0 = 1'b0;
        go(c0 + 10);
        @(negedge clk);
        chk("t2_tie2_gnt1", 32'({gnt0, gnt1}), 32'b01);
        go(c0 + 12);
        req1 = 1'b0;

        // Burst cap with a waiting peer.
        step();
        c0 = cyc;
        a = AW'($urandom_range(0, 127));
        drive(0, 1'b1, 1'b1, 1'b0, a, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h90, '0);
        exp_rd(0, a, c0 + 2);
        exp_rd(1, 8'h90, c0 + 26);
        for (int k = 1; k < MB; k++) begin
            go(c0 + 3 * k);
            a = AW'($urandom_range(0, 127));
            addr0 = a;
            exp_rd(0, a, c0 + 3 * k + 2);
            @(negedge clk);
            chk("t4_hold_gnt", 32'({gnt0, gnt1}), 32'b10);
        end
        go(c0 + 24);
        a = AW'($urandom_range(0, 127));
        addr0 = a;
        exp_rd(0, a, c0 + 29);
        @(negedge clk);
        chk("t4_cap_release", 32'(busy), 0);
        go(c0 + 25);
        @(negedge clk);
        chk("t4_peer_gnt", 32'({gnt0, gnt1}), 32'b01);
        go(c0 + 27);
        req1 = 1'b0;
        go(c0 + 30);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Single read of a known word.
        step();
        c0 = cyc;
        drive(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
        exp_rd(0, 8'h10, c0 + 2);
        @(negedge clk);
        chk("t1_no_comb_gnt", 32'(gnt0), 0);
        go(c0 + 1);
        @(negedge clk);
        chk("t1_gnt0", 32'(gnt0), 1);
        chk("t1_addr", 32'(mem_addr), 32'h10);
        chk("t1_wr_en", 32'(mem_wr_en), 0);
        go(c0 + 3);
        req0 = 1'b0;
        @(negedge clk);
        chk("t1_idle", 32'(busy), 0);

        // Write by req1, readback by req0.
        step();
        c0 = cyc;
        drive(1, 1'b1, 1'b0, 1'b1, 8'h20, 16'h1234);
        exp_wr(1, 8'h20, 16'h1234, c0 + 2);
        @(negedge clk);
        chk("t3_we_before", 32'(mem_wr_en), 0);
        go(c0 + 1);
        @(negedge clk);
        chk("t3_we", 32'(mem_wr_en), 1);
        chk("t3_wdata", 32'(mem_wdata), 32'h1234);
        chk("t3_waddr", 32'(mem_addr), 32'h20);
        go(c0 + 2);
        @(negedge clk);
        chk("t3_we_after", 32'(mem_wr_en), 0);
        go(c0 + 3);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h20, '0);
        exp_rd(0, 8'h20, c0 + 5);
        go(c0 + 6);
        req0 = 1'b0;

        // Lock dropped during the third access of a burst.
        step();
        c0 = cyc;
        a = AW'($urandom_range(0, 127));
        drive(0, 1'b1, 1'b1, 1'b0, a, '0);
        exp_rd(0, a, c0 + 2);
        go(c0 + 1);
        drive(1, 1'b1, 1'b0, 1'b0, 8'hA0, '0);
        exp_rd(1, 8'hA0, c0 + 11);
        go(c0 + 3);
        a = AW'($urandom_range(0, 127));
        addr0 = a;
        exp_rd(0, a, c0 + 5);
        go(c0 + 6);
        a = AW'($urandom_range(0, 127));
        addr0 = a;
        exp_rd(0, a, c0 + 8);
        go(c0 + 7);
        lock0 = 1'b0;
        go(c0 + 9);
        req0 = 1'b0;
        @(negedge clk);
        chk("t5_release", 32'(busy), 0);
        go(c0 + 10);
        @(negedge clk);
        chk("t5_peer_gnt", 32'({gnt0, gnt1}), 32'b01);
        go(c0 + 12);
        req1 = 1'b0;

        // Reset in the middle of a write.
        step();
        c0 = cyc;
        drive(0, 1'b1, 1'b0, 1'b1, 8'h30, 16'h5555);
        go(c0 + 1);
        chk("t6_pre_we", 32'(mem_wr_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_we", 32'(mem_wr_en), 0);
        chk("t6_rst_gnt", 32'({gnt0, gnt1}), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        go(c0 + 3);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 8'h31, '0);
        drive(1, 1'b1, 1'b0, 1'b0, 8'hB0, '0);
        exp_rd(0, 8'h31, c0 + 5);
        exp_rd(1, 8'hB0, c0 + 8);
        go(c0 + 4);
        @(negedge clk);
        chk("t6_tie_gnt0", 32'({gnt0, gnt1}), 32'b10);
        go(c0 + 6);
        req0 = 1'b0;
        go(c0 + 9);
        req1 = 1'b0;

        // Random traffic from both requesters on disjoint address halves.
        step();
        fork
            requester(0);
            requester(1);
        join
        repeat (6) step();
        chk("sb0_drained", 32'(sb0.size()), 0);
        chk("sb1_drained", 32'(sb1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
